// File: rtl/hazard_unit_mc.sv
// Pipeline hazard controller for the 5-stage MIPS core: multi-cycle load-use and MDU-busy
// stalls, jump/branch flushes, and a saturating stall-cycle counter.
module hazard_unit_mc #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_mdu_read,
  input  logic              id_mdu_start,
  input  logic [1:0]        pc_src_id,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_mem_read,
  input  logic              ex_branch,
  input  logic              ex_zero,
  input  logic              ex_mdu_start,
  output logic [1:0]        pc_ctrl,
  output logic [1:0]        ifid_ctrl,
  output logic [1:0]        idex_ctrl,
  output logic              stall_active,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int unsigned LuW  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned MduW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;

  localparam logic [1:0] CtrlNormal = 2'b00;
  localparam logic [1:0] CtrlFlush  = 2'b01;
  localparam logic [1:0] CtrlHold   = 2'b10;

  logic [LuW-1:0]   lu_cnt_q, lu_cnt_d;
  logic [MduW-1:0]  mdu_cnt_q, mdu_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic lu_hit, lu_stall, mdu_busy, mdu_stall, taken, stall, jump;

  always_comb begin
    lu_hit    = ex_mem_read && (ex_rt != '0) &&
                ((id_uses_rs && (ex_rt == id_rs)) || (id_uses_rt && (ex_rt == id_rt)));
    lu_stall  = lu_hit || (lu_cnt_q != '0);
    mdu_busy  = ex_mdu_start || (mdu_cnt_q != '0);
    mdu_stall = mdu_busy && (id_mdu_read || id_mdu_start);
    taken     = ex_branch && ex_zero;
    stall     = !taken && (lu_stall || mdu_stall);
    jump      = (pc_src_id == 2'b01) || (pc_src_id == 2'b10);
  end

  // A held jump is only flushed once the stall releases, since stall outranks jump.
  always_comb begin
    pc_ctrl   = CtrlNormal;
    ifid_ctrl = CtrlNormal;
    idex_ctrl = CtrlNormal;
    if (!reset) begin
      if (taken) begin
        ifid_ctrl = CtrlFlush;
        idex_ctrl = CtrlFlush;
      end else if (stall) begin
        pc_ctrl   = CtrlHold;
        ifid_ctrl = CtrlHold;
        idex_ctrl = CtrlFlush;
      end else if (jump) begin
        ifid_ctrl = CtrlFlush;
      end
    end
    stall_active = (pc_ctrl == CtrlHold);
  end

  always_comb begin
    lu_cnt_d = lu_cnt_q;
    if (taken) begin
      lu_cnt_d = '0;
    end else if (lu_hit) begin
      lu_cnt_d = LuW'(MEM_LAT - 1);
    end else if (lu_cnt_q != '0) begin
      lu_cnt_d = lu_cnt_q - LuW'(1);
    end

    // The MDU keeps running across a taken branch; its op has already issued.
    mdu_cnt_d = mdu_cnt_q;
    if (ex_mdu_start) begin
      mdu_cnt_d = MduW'(MDU_LAT - 1);
    end else if (mdu_cnt_q != '0) begin
      mdu_cnt_d = mdu_cnt_q - MduW'(1);
    end

    stall_cycles_d = stall_cycles_q;
    if (stall_active && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lu_cnt_q       <= '0;
      mdu_cnt_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      lu_cnt_q       <= lu_cnt_d;
      mdu_cnt_q      <= mdu_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: two instances (MEM_LAT=1 and MEM_LAT=3 with a 3-bit counter) share
// stimulus; a deadline-based model checks every cycle, directed literals pin key scenarios.
module tb_hazard_unit_mc;

  localparam int unsigned MduLat = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rs, id_uses_rt, id_mdu_read, id_mdu_start;
  logic [1:0] pc_src_id;
  logic       ex_mem_read, ex_branch, ex_zero, ex_mdu_start;

  logic [1:0]  pc_c[2], ifid_c[2], idex_c[2];
  logic        sa_c[2];
  logic [31:0] sc1;
  logic [2:0]  sc3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(5), .MEM_LAT(1), .MDU_LAT(MduLat), .CNT_W(32)) d1 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_mdu_read(id_mdu_read), .id_mdu_start(id_mdu_start),
    .pc_src_id(pc_src_id), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_branch(ex_branch),
    .ex_zero(ex_zero), .ex_mdu_start(ex_mdu_start), .pc_ctrl(pc_c[0]), .ifid_ctrl(ifid_c[0]),
    .idex_ctrl(idex_c[0]), .stall_active(sa_c[0]), .stall_cycles(sc1)
  );

  hazard_unit_mc #(.REG_AW(5), .MEM_LAT(3), .MDU_LAT(MduLat), .CNT_W(3)) d3 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_mdu_read(id_mdu_read), .id_mdu_start(id_mdu_start),
    .pc_src_id(pc_src_id), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_branch(ex_branch),
    .ex_zero(ex_zero), .ex_mdu_start(ex_mdu_start), .pc_ctrl(pc_c[1]), .ifid_ctrl(ifid_c[1]),
    .idex_ctrl(idex_c[1]), .stall_active(sa_c[1]), .stall_cycles(sc3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each hazard is a deadline (last cycle it still forces a stall).
  longint    t = 0;
  longint    lu_until[2] = '{-1, -1};
  longint    mdu_until[2] = '{-1, -1};
  longint    cnt[2] = '{0, 0};
  int        lat[2] = '{1, 3};
  longint    cmax[2] = '{64'hFFFF_FFFF, 7};

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        bit hit, lus, ms, tk, st, jp;
        logic [1:0] e_pc, e_ifid, e_idex;
        logic [31:0] act_sc;
        hit = ex_mem_read && ex_rt != 0 &&
              ((id_uses_rs && ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt));
        lus = hit || (t <= lu_until[k]);
        ms  = (ex_mdu_start || (t <= mdu_until[k])) && (id_mdu_read || id_mdu_start);
        tk  = ex_branch && ex_zero;
        st  = !tk && (lus || ms);
        jp  = (pc_src_id == 2'd1) || (pc_src_id == 2'd2);
        e_pc = 2'b00; e_ifid = 2'b00; e_idex = 2'b00;
        if (!reset) begin
          if (tk) begin e_ifid = 2'b01; e_idex = 2'b01; end
          else if (st) begin e_pc = 2'b10; e_ifid = 2'b10; e_idex = 2'b01; end
          else if (jp) e_ifid = 2'b01;
        end
        act_sc = (k == 0) ? sc1 : {29'd0, sc3};
        chk($sformatf("m%0d_pc", k), {30'd0, pc_c[k]}, {30'd0, e_pc});
        chk($sformatf("m%0d_ifid", k), {30'd0, ifid_c[k]}, {30'd0, e_ifid});
        chk($sformatf("m%0d_idex", k), {30'd0, idex_c[k]}, {30'd0, e_idex});
        chk($sformatf("m%0d_sa", k), {31'd0, sa_c[k]}, {31'd0, (e_pc == 2'b10)});
        chk($sformatf("m%0d_sc", k), act_sc, cnt[k][31:0]);
        if (reset) begin
          lu_until[k] = t; mdu_until[k] = t; cnt[k] = 0;
        end else begin
          if (tk) lu_until[k] = t;
          else if (hit) lu_until[k] = t + lat[k] - 1;
          if (ex_mdu_start) mdu_until[k] = t + MduLat - 1;
          if (st && cnt[k] < cmax[k]) cnt[k]++;
        end
      end
      t++;
    end
  end

  task automatic clr();
    id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_mdu_read = 0; id_mdu_start = 0; pc_src_id = 0;
    ex_mem_read = 0; ex_branch = 0; ex_zero = 0; ex_mdu_start = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use5();
    ex_mem_read = 1; ex_rt = 5; id_uses_rs = 1; id_rs = 5;
  endtask

  task automatic bubble_keep_id();
    ex_mem_read = 0; ex_rt = 0;
  endtask

  initial begin
    clr(); reset = 1;
    tick();
    load_use5(); #1;
    chk("rst_pc", {30'd0, pc_c[1]}, 32'd0);
    chk("rst_sa", {31'd0, sa_c[0]}, 32'd0);
    tick(); reset = 0; clr(); #1;
    chk("rst_sc", {29'd0, sc3}, 32'd0);

    // T1/T2: lw $5 in EX, ID uses rs=5
    tick(); load_use5(); #1;
    chk("t1_pc", {30'd0, pc_c[0]}, 32'h2);
    chk("t1_ifid", {30'd0, ifid_c[0]}, 32'h2);
    chk("t1_idex", {30'd0, idex_c[0]}, 32'h1);
    tick(); bubble_keep_id(); #1;
    chk("t1_rel", {30'd0, pc_c[0]}, 32'h0);
    chk("t1_sc", sc1, 32'd1);
    chk("t2_c1", {30'd0, pc_c[1]}, 32'h2);
    tick(); #1;
    chk("t2_c2", {30'd0, pc_c[1]}, 32'h2);
    tick(); #1;
    chk("t2_rel", {30'd0, pc_c[1]}, 32'h0);
    chk("t2_sc", {29'd0, sc3}, 32'd3);

    // T4: taken branch while d3 has lu_cnt=1
    tick(); load_use5();
    tick(); bubble_keep_id();
    tick(); ex_branch = 1; ex_zero = 1; #1;
    chk("t4_pc", {30'd0, pc_c[1]}, 32'h0);
    chk("t4_ifid", {30'd0, ifid_c[1]}, 32'h1);
    chk("t4_idex", {30'd0, idex_c[1]}, 32'h1);
    tick(); ex_branch = 0; ex_zero = 0; #1;
    chk("t4_after", {30'd0, pc_c[1]}, 32'h0);
    chk("t4_sc", {29'd0, sc3}, 32'd5);

    // T5: jump held during d3 stall, flushed once released; d3 counter saturates at 7
    tick(); load_use5(); pc_src_id = 2'b01; #1;
    chk("t5_h0", {30'd0, ifid_c[1]}, 32'h2);
    tick(); bubble_keep_id(); #1;
    chk("t5_h1", {30'd0, ifid_c[1]}, 32'h2);
    chk("t5_d1jmp", {30'd0, ifid_c[0]}, 32'h1);
    tick(); #1;
    chk("t5_h2", {30'd0, ifid_c[1]}, 32'h2);
    tick(); #1;
    chk("t5_flush", {30'd0, ifid_c[1]}, 32'h1);
    chk("t5_idex", {30'd0, idex_c[1]}, 32'h0);
    chk("sat_sc", {29'd0, sc3}, 32'd7);

    // T3: MDU start with mfhi in ID
    tick(); clr(); ex_mdu_start = 1; id_mdu_read = 1; #1;
    chk("t3_s0", {30'd0, pc_c[0]}, 32'h2);
    tick(); ex_mdu_start = 0;
    tick();
    tick(); #1;
    chk("t3_s3", {30'd0, pc_c[0]}, 32'h2);
    tick(); #1;
    chk("t3_go", {30'd0, pc_c[0]}, 32'h0);
    chk("t3_sc", sc1, 32'd7);
    chk("sat_hold", {29'd0, sc3}, 32'd7);

    // T6: r0 never hazards; reset mid-stall
    tick(); clr(); ex_mem_read = 1; id_uses_rs = 1; #1;
    chk("t6_r0", {30'd0, pc_c[0]}, 32'h0);
    chk("t6_r0b", {30'd0, pc_c[1]}, 32'h0);
    tick(); load_use5();
    tick(); bubble_keep_id(); reset = 1; #1;
    chk("t6_rpc", {30'd0, pc_c[1]}, 32'h0);
    chk("t6_rsa", {31'd0, sa_c[1]}, 32'd0);
    tick(); reset = 0; clr(); #1;
    chk("t6_pc", {30'd0, pc_c[1]}, 32'h0);
    chk("t6_sc", {29'd0, sc3}, 32'd0);

    // Mixed traffic, checked by the model every cycle
    for (int i = 0; i < 300; i++) begin
      tick();
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_rt = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom_range(0, 1)); id_uses_rt = 1'($urandom_range(0, 1));
      ex_mem_read = ($urandom_range(0, 2) == 0);
      id_mdu_read = ($urandom_range(0, 3) == 0); id_mdu_start = ($urandom_range(0, 5) == 0);
      ex_mdu_start = ($urandom_range(0, 7) == 0);
      pc_src_id = 2'($urandom_range(0, 3));
      ex_branch = ($urandom_range(0, 4) == 0); ex_zero = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 31) == 0);
    end
    tick(); clr(); reset = 0;
    tick(); tick();
    @(posedge clk); #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
